// File: rtl/pdp8l_pkg.sv
// Shared definitions for the PDP-8/L I/O bus sequencer/arbiter: sequencer
// state encoding, ARM register indices and identification constants.
package pdp8l_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_START  = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_STOP   = 2'd3
   } seq_state_e;

   localparam logic [1:0]  REG_IDENT = 2'd0;
   localparam logic [1:0]  REG_MASK  = 2'd1;
   localparam logic [1:0]  REG_STAT  = 2'd2;
   localparam logic [1:0]  REG_TCNT  = 2'd3;

   localparam logic [15:0] IDENT_IA    = 16'h4941;
   localparam logic [3:0]  REG_LOG2M1  = 4'd1;
   localparam logic [11:0] ARB_VERSION = 12'h001;

endpackage

// File: rtl/pdp8l_iobus_or.sv
// Masked OR-reduction of device slot responses plus a lowest-slot-first
// interrupt source encoder. Purely combinational; the parent registers it.
module pdp8l_iobus_or #(
   parameter int NDEV = 4
) (
   input  logic [12*NDEV-1:0] dev_devtocpu_i,
   input  logic [NDEV-1:0]    dev_acclr_i,
   input  logic [NDEV-1:0]    dev_skip_i,
   input  logic [NDEV-1:0]    dev_intrq_i,
   input  logic [NDEV-1:0]    en_i,
   input  logic [NDEV-1:0]    ie_i,
   output logic [11:0]        data_o,
   output logic               acclr_o,
   output logic               skip_o,
   output logic               intrq_o,
   output logic [3:0]         irqsrc_o
);

   always_comb begin
      data_o   = '0;
      acclr_o  = 1'b0;
      skip_o   = 1'b0;
      intrq_o  = 1'b0;
      irqsrc_o = 4'hF;
      // Walk from the top slot down so the lowest passing slot is left in irqsrc_o.
      for (int k = NDEV - 1; k >= 0; k--) begin
         if (en_i[k]) begin
            data_o  = data_o | dev_devtocpu_i[12*k +: 12];
            acclr_o = acclr_o | dev_acclr_i[k];
            skip_o  = skip_o | dev_skip_i[k];
         end
         if (en_i[k] && ie_i[k] && dev_intrq_i[k]) begin
            intrq_o  = 1'b1;
            irqsrc_o = 4'(k);
         end
      end
   end

endmodule

// File: rtl/pdp8l_iobus_arb.sv
// PDP-8/L I/O bus sequencer and arbiter: frames IOT pulses into transactions
// and merges device responses. Conflict detection built when PDP8L_IOARB_CONFLICT_EN is defined.
module pdp8l_iobus_arb
   import pdp8l_pkg::*;
#(
   parameter int NDEV   = 4,
   parameter int GAPCNT = 8
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              CSTEP,
   input  logic              armwrite,
   input  logic [1:0]        armraddr,
   input  logic [1:0]        armwaddr,
   input  logic [31:0]       armwdata,
   output logic [31:0]       armrdata,
   input  logic [2:0]        iop_in,
   input  logic [11:0]       instr,
   output logic              iopstart,
   output logic              iopstop,
   output logic [11:0]       ioopcode,
   input  logic [12*NDEV-1:0] dev_devtocpu,
   input  logic [NDEV-1:0]   dev_acclr,
   input  logic [NDEV-1:0]   dev_skip,
   input  logic [NDEV-1:0]   dev_intrq,
   output logic [11:0]       devtocpu,
   output logic              AC_CLEAR,
   output logic              IO_SKIP,
   output logic              INT_RQST
);

   localparam logic [7:0] GAP_INIT = 8'(GAPCNT);

   seq_state_e       state_q;
   logic             iopstart_q, iopstop_q;
   logic [11:0]      ioopcode_q;
   logic [7:0]       gap_q;
   logic [31:0]      tcnt_q;
   logic [NDEV-1:0]  en_q, ie_q;
   logic [11:0]      devtocpu_q;
   logic             acclr_q, skip_q, intrq_q;
   logic [3:0]       irqsrc_q;

   logic [11:0]      or_data_d;
   logic             or_acclr_d, or_skip_d, or_intrq_d;
   logic [3:0]       or_irqsrc_d;

   logic             conf_sticky;
   logic [7:0]       conf_cnt;
   logic             unused_wdata;

   assign unused_wdata = ^armwdata;

   // Sequencer: every transition is gated by CSTEP; the pulses last one step.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         iopstart_q <= 1'b0;
         iopstop_q  <= 1'b0;
         ioopcode_q <= '0;
         gap_q      <= '0;
         tcnt_q     <= '0;
      end else if (CSTEP) begin
         iopstart_q <= 1'b0;
         iopstop_q  <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (|iop_in) begin
                  ioopcode_q <= instr;
                  tcnt_q     <= tcnt_q + 32'd1;
                  iopstart_q <= 1'b1;
                  state_q    <= ST_START;
               end
            end
            ST_START: begin
               gap_q   <= GAP_INIT;
               state_q <= ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (|iop_in) begin
                  gap_q <= GAP_INIT;
               end else if (gap_q <= 8'd1) begin
                  gap_q     <= '0;
                  iopstop_q <= 1'b1;
                  state_q   <= ST_STOP;
               end else begin
                  gap_q <= gap_q - 8'd1;
               end
            end
            ST_STOP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         en_q <= '0;
         ie_q <= '1;
      end else if (armwrite && (armwaddr == REG_MASK)) begin
         en_q <= armwdata[NDEV-1:0];
         ie_q <= armwdata[NDEV+15:16];
      end
   end

   pdp8l_iobus_or #(.NDEV(NDEV)) u_or (
      .dev_devtocpu_i (dev_devtocpu),
      .dev_acclr_i    (dev_acclr),
      .dev_skip_i     (dev_skip),
      .dev_intrq_i    (dev_intrq),
      .en_i           (en_q),
      .ie_i           (ie_q),
      .data_o         (or_data_d),
      .acclr_o        (or_acclr_d),
      .skip_o         (or_skip_d),
      .intrq_o        (or_intrq_d),
      .irqsrc_o       (or_irqsrc_d)
   );

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         devtocpu_q <= '0;
         acclr_q    <= 1'b0;
         skip_q     <= 1'b0;
         intrq_q    <= 1'b0;
         irqsrc_q   <= 4'hF;
      end else begin
         devtocpu_q <= or_data_d;
         acclr_q    <= or_acclr_d;
         skip_q     <= or_skip_d;
         intrq_q    <= or_intrq_d;
         irqsrc_q   <= or_irqsrc_d;
      end
   end

`ifdef PDP8L_IOARB_CONFLICT_EN
   logic [4:0] ndrv_d;
   logic       conflict_d;
   logic       conf_prev_q, conf_sticky_q;
   logic [7:0] conf_cnt_q;
   logic       conf_clr;

   always_comb begin
      ndrv_d = '0;
      for (int k = 0; k < NDEV; k++) begin
         if (en_q[k] && ((|dev_devtocpu[12*k +: 12]) || dev_skip[k])) begin
            ndrv_d = ndrv_d + 5'd1;
         end
      end
   end

   assign conflict_d = (state_q == ST_ACTIVE) && (ndrv_d >= 5'd2);
   assign conf_clr   = armwrite && (armwaddr == REG_STAT) && armwdata[31];

   // Count on the rising edge of a conflict only; an ARM clear overrides it.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         conf_prev_q   <= 1'b0;
         conf_sticky_q <= 1'b0;
         conf_cnt_q    <= '0;
      end else begin
         conf_prev_q <= conflict_d;
         if (conf_clr) begin
            conf_sticky_q <= 1'b0;
            conf_cnt_q    <= '0;
         end else if (conflict_d && !conf_prev_q) begin
            conf_sticky_q <= 1'b1;
            if (conf_cnt_q != 8'hFF) conf_cnt_q <= conf_cnt_q + 8'd1;
         end
      end
   end

   assign conf_sticky = conf_sticky_q;
   assign conf_cnt    = conf_cnt_q;
`else
   assign conf_sticky = 1'b0;
   assign conf_cnt    = 8'h00;
`endif

   always_comb begin
      armrdata = '0;
      unique case (armraddr)
         REG_IDENT: armrdata = {IDENT_IA, REG_LOG2M1, ARB_VERSION};
         REG_MASK: begin
            armrdata[NDEV-1:0]     = en_q;
            armrdata[NDEV+15:16]   = ie_q;
         end
         REG_STAT:  armrdata = {conf_sticky, 3'b000, irqsrc_q, conf_cnt, 2'b00, state_q, ioopcode_q};
         REG_TCNT:  armrdata = tcnt_q;
         default:   armrdata = '0;
      endcase
   end

   assign iopstart = iopstart_q;
   assign iopstop  = iopstop_q;
   assign ioopcode = ioopcode_q;
   assign devtocpu = devtocpu_q;
   assign AC_CLEAR = acclr_q;
   assign IO_SKIP  = skip_q;
   assign INT_RQST = intrq_q;

endmodule

// File: tb/tb_pdp8l_iobus_arb.sv
// Self-checking bench for pdp8l_iobus_arb: transaction-level sequencer model
// and response model feeding expected queues drained by a monitor.
module tb_pdp8l_iobus_arb;

   localparam int NDEV   = 4;
   localparam int GAPCNT = 8;

   logic              CLOCK;
   logic              RESET, CSTEP, armwrite;
   logic [1:0]        armraddr, armwaddr;
   logic [31:0]       armwdata, armrdata;
   logic [2:0]        iop_in;
   logic [11:0]       instr, ioopcode, devtocpu;
   logic              iopstart, iopstop, AC_CLEAR, IO_SKIP, INT_RQST;
   logic [12*NDEV-1:0] dev_devtocpu;
   logic [NDEV-1:0]   dev_acclr, dev_skip, dev_intrq;

   pdp8l_iobus_arb #(.NDEV(NDEV), .GAPCNT(GAPCNT)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .CSTEP(CSTEP),
      .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
      .armwdata(armwdata), .armrdata(armrdata),
      .iop_in(iop_in), .instr(instr),
      .iopstart(iopstart), .iopstop(iopstop), .ioopcode(ioopcode),
      .dev_devtocpu(dev_devtocpu), .dev_acclr(dev_acclr),
      .dev_skip(dev_skip), .dev_intrq(dev_intrq),
      .devtocpu(devtocpu), .AC_CLEAR(AC_CLEAR), .IO_SKIP(IO_SKIP), .INT_RQST(INT_RQST)
   );

   // ---------------- clock ----------------
   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [29:0] exp_q[$];   // {kind(1=start,2=stop), opcode, step}
   logic [18:0] rsp_q[$];   // {irqsrc, intrq, skip, acclr, data}

   // transaction-level model
   logic [NDEV-1:0] m_en, m_ie;
   bit          m_busy, m_stopping;
   int          m_age, m_idle_run, m_step;
   int unsigned m_tcnt;
   logic [11:0] m_op;
   int          mon_step;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [18:0] resp_model();
      logic [11:0] d;
      logic ac, sk;
      int pass_q[$];
      d = '0; ac = 1'b0; sk = 1'b0;
      for (int k = 0; k < NDEV; k++) begin
         if (m_en[k]) begin
            d  = d | dev_devtocpu[12*k +: 12];
            ac = ac | dev_acclr[k];
            sk = sk | dev_skip[k];
         end
         if (m_en[k] && m_ie[k] && dev_intrq[k]) pass_q.push_back(k);
      end
      if (pass_q.size() > 0) return {4'(pass_q[0]), 1'b1, sk, ac, d};
      return {4'hF, 1'b0, sk, ac, d};
   endfunction

   // One CSTEP seen by the model: transaction opens on IOP in idle, the first
   // step after opening ignores IOP, then GAPCNT quiet steps close it, and one
   // more step returns to idle.
   task automatic seq_model();
      m_step++;
      if (!m_busy) begin
         if (iop_in != 3'd0) begin
            m_busy = 1; m_age = 0; m_idle_run = 0; m_stopping = 0;
            m_op = instr; m_tcnt++;
            exp_q.push_back({2'd1, instr, 16'(m_step)});
         end
      end else begin
         m_age++;
         if (m_stopping) m_busy = 0;
         else if (m_age >= 2) begin
            if (iop_in != 3'd0) m_idle_run = 0;
            else m_idle_run++;
            if (m_idle_run == GAPCNT) begin
               m_stopping = 1;
               exp_q.push_back({2'd2, m_op, 16'(m_step)});
            end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input logic cs);
      CSTEP = cs;
      if (RESET) begin
         rsp_q.push_back({4'hF, 15'd0});
         m_step = 0; m_busy = 0; m_stopping = 0; m_tcnt = 0;
         m_en = '0; m_ie = '1;
      end else begin
         rsp_q.push_back(resp_model());
         if (cs) seq_model();
         if (armwrite && armwaddr == 2'd1) begin
            m_en = armwdata[NDEV-1:0];
            m_ie = armwdata[NDEV+15:16];
         end
      end
      @(posedge CLOCK);
      @(negedge CLOCK);
      armwrite = 1'b0;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         tick(1'b1);
         tick(1'b0);
      end
   endtask

   task automatic arm_wr(input logic [1:0] a, input logic [31:0] d);
      armwrite = 1'b1; armwaddr = a; armwdata = d;
      tick(1'b0);
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      armraddr = a;
      #1;
      v = armrdata;
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [29:0] e;
      logic [18:0] r;
      logic prev_start, prev_stop;
      int start_at, stop_at;
      prev_start = 1'b0; prev_stop = 1'b0; start_at = 0; stop_at = 0; mon_step = 0;
      forever begin
         @(posedge CLOCK);
         #1;
         if (RESET) mon_step = 0;
         else if (CSTEP) mon_step++;
         if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            check("resp", {17'd0, INT_RQST, IO_SKIP, AC_CLEAR, devtocpu}, {17'd0, r[14:0]});
            if (armraddr == 2'd2) check("irqsrc", {28'd0, armrdata[27:24]}, {28'd0, r[18:15]});
         end
         if (iopstart && !prev_start) begin
            start_at = mon_step;
            if (exp_q.size() == 0) check("start_unexpected", {31'd0, iopstart}, 32'd0);
            else begin
               e = exp_q.pop_front();
               check("start_kind", 32'd1, {30'd0, e[29:28]});
               check("start_opcode", {20'd0, ioopcode}, {20'd0, e[27:16]});
               check("start_step", mon_step, {16'd0, e[15:0]});
            end
         end
         if (!iopstart && prev_start && !RESET) check("start_width", mon_step, start_at + 1);
         if (iopstop && !prev_stop) begin
            stop_at = mon_step;
            if (exp_q.size() == 0) check("stop_unexpected", {31'd0, iopstop}, 32'd0);
            else begin
               e = exp_q.pop_front();
               check("stop_kind", 32'd2, {30'd0, e[29:28]});
               check("stop_opcode", {20'd0, ioopcode}, {20'd0, e[27:16]});
               check("stop_step", mon_step, {16'd0, e[15:0]});
            end
         end
         if (!iopstop && prev_stop && !RESET) check("stop_width", mon_step, stop_at + 1);
         prev_start = iopstart;
         prev_stop  = iopstop;
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] v;
      RESET = 1'b1; CSTEP = 1'b0; armwrite = 1'b0; armraddr = 2'd0; armwaddr = 2'd0;
      armwdata = '0; iop_in = '0; instr = '0; dev_devtocpu = '0;
      dev_acclr = '0; dev_skip = '0; dev_intrq = '0;
      m_en = '0; m_ie = '1; m_busy = 0; m_stopping = 0; m_age = 0; m_idle_run = 0;
      m_step = 0; m_tcnt = 0; m_op = '0;

      tick(1'b1); tick(1'b0); tick(1'b1);
      rd(2'd0, v); check("reg0_ident", v, 32'h4941_1001);
      rd(2'd1, v); check("reg1_reset", v, 32'h000F_0000);
      rd(2'd2, v); check("reg2_reset", v, 32'h0F00_0000);
      rd(2'd3, v); check("reg3_reset", v, 32'd0);
      check("outs_reset", {26'd0, iopstart, iopstop, devtocpu == 12'd0, AC_CLEAR, IO_SKIP, INT_RQST},
            {26'd0, 6'b001000});
      check("ioopcode_reset", {20'd0, ioopcode}, 32'd0);
      RESET = 1'b0;

      // single framed transaction
      iop_in = 3'b001; instr = 12'o6012;
      step(2);
      iop_in = 3'b000;
      step(12);
      check("opcode_latched", {20'd0, ioopcode}, {20'd0, 12'o6012});
      rd(2'd3, v); check("tcnt_one", v, m_tcnt);

      // short gap does not split the transaction
      iop_in = 3'b001; instr = 12'o6046;
      step(1);
      iop_in = 3'b000; step(3);
      iop_in = 3'b010; step(1);
      iop_in = 3'b000; step(12);
      rd(2'd3, v); check("tcnt_two", v, m_tcnt);

      // randomized traffic
      armraddr = 2'd2;
      for (int i = 0; i < 700; i++) begin
         iop_in = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         instr  = 12'($urandom);
         for (int k = 0; k < NDEV; k++)
            dev_devtocpu[12*k +: 12] = ($urandom_range(0, 2) == 0) ? 12'($urandom) : 12'd0;
         dev_acclr = NDEV'($urandom);
         dev_skip  = NDEV'($urandom);
         dev_intrq = NDEV'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            armwrite = 1'b1; armwaddr = 2'($urandom); armwdata = $urandom;
         end
         tick(1'($urandom_range(0, 1)));
      end
      iop_in = 3'b000;
      step(20);
      rd(2'd3, v); check("tcnt_random", v, m_tcnt);

      // enable mask on data
      dev_devtocpu = '0; dev_acclr = '0; dev_skip = '0; dev_intrq = '0;
      dev_devtocpu[11:0]  = 12'o0101;
      dev_devtocpu[35:24] = 12'o7777;
      arm_wr(2'd1, 32'h000F_0003);
      tick(1'b0);
      check("en_0011", {20'd0, devtocpu}, {20'd0, 12'o0101});
      arm_wr(2'd1, 32'h000F_0007);
      check("en_lag", {20'd0, devtocpu}, {20'd0, 12'o0101});
      tick(1'b0);
      check("en_0111", {20'd0, devtocpu}, {20'd0, 12'o7777});

      // interrupt gating and source
      dev_intrq = 4'b1010;
      arm_wr(2'd1, 32'h000D_000F);
      tick(1'b0);
      rd(2'd2, v);
      check("irq_on", {31'd0, INT_RQST}, 32'd1);
      check("irqsrc_3", {28'd0, v[27:24]}, 32'd3);
      arm_wr(2'd1, 32'h0005_000F);
      tick(1'b0);
      rd(2'd2, v);
      check("irq_off", {31'd0, INT_RQST}, 32'd0);
      check("irqsrc_none", {28'd0, v[27:24]}, 32'hF);

      // two slots skipping during ACTIVE
      dev_devtocpu = '0; dev_intrq = '0;
      arm_wr(2'd2, 32'h8000_0000);
      iop_in = 3'b001; instr = 12'o6031;
      step(2);
      dev_skip = 4'b0110;
      step(5);
      dev_skip = 4'b0000;
      tick(1'b0);
      rd(2'd2, v);
`ifdef PDP8L_IOARB_CONFLICT_EN
      check("conflict_sticky", {31'd0, v[31]}, 32'd1);
      check("conflict_count", {24'd0, v[23:16]}, 32'd1);
`else
      check("conflict_sticky_absent", {31'd0, v[31]}, 32'd0);
      check("conflict_count_absent", {24'd0, v[23:16]}, 32'd0);
`endif
      arm_wr(2'd2, 32'h8000_0000);
      rd(2'd2, v);
      check("conflict_sticky_clr", {31'd0, v[31]}, 32'd0);
      check("conflict_count_clr", {24'd0, v[23:16]}, 32'd0);
      iop_in = 3'b000;
      step(12);

      // reset in the middle of a transaction
      iop_in = 3'b001; instr = 12'o6022;
      step(1);
      iop_in = 3'b000;
      step(2);
      rd(2'd2, v); check("state_active", {30'd0, v[13:12]}, 32'd2);
      dev_devtocpu[23:12] = 12'o1234;
      tick(1'b0);
      check("data_pre_reset", {20'd0, devtocpu}, {20'd0, 12'o1234});
      RESET = 1'b1;
      tick(1'b1);
      rd(2'd2, v); check("state_after_reset", {30'd0, v[13:12]}, 32'd0);
      check("outs_after_reset", {20'd0, iopstart, iopstop, devtocpu == 12'd0, AC_CLEAR, IO_SKIP, INT_RQST,
            6'd0}, {20'd0, 6'b001000, 6'd0});
      check("opcode_after_reset", {20'd0, ioopcode}, 32'd0);
      RESET = 1'b0;
      step(15);

      tick(1'b0);
      check("events_drained", exp_q.size(), 32'd0);
      check("resp_drained", rsp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
